load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, alignment helper.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_e;

    // The reserved size code behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational.
module lsu_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
        case (size)
            SZ_BYTE: begin
                shamt     = {~offset, 3'b000};
                lane_mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                shamt     = {~offset[1], 4'b0000};
                lane_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase

        lane8  = 8'(word_in >> shamt);
        lane16 = 16'(word_in >> shamt);
        merged = (word_in & ~(lane_mask << shamt)) | ((store_data & lane_mask) << shamt);

        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & lane8[7]}}, lane8};
            SZ_HALF: load_data = {{16{sign_ext & lane16[15]}}, lane16};
            default: load_data = word_in;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access, read-modify-write for sub-word stores.
// Optional misalignment trap under LSU_MISALIGN_TRAP_EN; otherwise low address bits are ignored.
module load_store_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] load_data, merged_data;
    logic              trap;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_lane_align u_align (
        .size      (size_q),
        .sign_ext  (signed_q),
        .offset    (addr_q[1:0]),
        .word_in   (mem_rdata),
        .store_data(wdata_q),
        .load_data (load_data),
        .merged    (merged_data)
    );

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    data_d   = '0;
                    err_d    = trap;
                    if (trap)           state_d = RESP;
                    else if (!req_write) state_d = READ;
                    else if (req_size[1]) state_d = WRITE;
                    else                state_d = RMW_RD;
                end
            end
            READ: begin
                data_d  = load_data;
                state_d = RESP;
            end
            WRITE:  state_d = RESP;
            RMW_RD: state_d = RMW_WR;
            RMW_WR: state_d = RESP;
            RESP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = data_q;
                resp_err_d   = err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Memory strobes are registered from the next state so they line up with it.
        case (state_d)
            READ, RMW_RD: begin
                mem_read_d = 1'b1;
                mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
            end
            WRITE: begin
                mem_write_d = 1'b1;
                mem_addr_d  = {addr_d[ADDR_W-1:2], 2'b00};
                mem_wdata_d = wdata_d;
            end
            RMW_WR: begin
                mem_write_d = 1'b1;
                mem_addr_d  = {addr_d[ADDR_W-1:2], 2'b00};
                mem_wdata_d = merged_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a byte-array memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] ram [0:63];
    logic [7:0]  refb [0:255];
    assign mem_rdata = ram[mem_addr[7:2]];

    int errors = 0;
    int checks = 0;

    logic [31:0] o_rdata, o_rd_addr, o_wr_data;
    logic        o_err, o_timeout;
    int          o_lat, o_nrd, o_nwr, o_bad;

    // Reference memory: plain byte array, byte at the lowest address is most significant.
    function automatic logic [31:0] ref_word(input logic [7:0] a);
        int b;
        b = int'(a) & 252;
        return {refb[b], refb[b+1], refb[b+2], refb[b+3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] sz, input logic sg);
        int x;
        int h;
        if (sz == 2'd0) begin
            x = int'(refb[a]);
            if (sg && x > 127) x -= 256;
        end else if (sz == 2'd1) begin
            h = int'(a) & 254;
            x = int'(refb[h]) * 256 + int'(refb[h+1]);
            if (sg && x > 32767) x -= 65536;
        end else begin
            return ref_word(a);
        end
        return 32'(x);
    endfunction

    function automatic logic ref_misaligned(input logic [7:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int b;
        if (sz == 2'd0) begin
            refb[a] = wd[7:0];
        end else if (sz == 2'd1) begin
            b = int'(a) & 254;
            refb[b]   = wd[15:8];
            refb[b+1] = wd[7:0];
        end else begin
            b = int'(a) & 252;
            for (int i = 0; i < 4; i++) refb[b+i] = 8'(wd >> (24 - 8 * i));
        end
    endtask

    task automatic set_word(input logic [7:0] a, input logic [31:0] v);
        ram[a[7:2]] = v;
        for (int i = 0; i < 4; i++) refb[(int'(a) & 252) + i] = 8'(v >> (24 - 8 * i));
    endtask

    function automatic logic exp_trap(input logic [7:0] a, input logic [1:0] sz);
`ifdef LSU_MISALIGN_TRAP_EN
        return ref_misaligned(a, sz);
`else
        return 1'b0 & ref_misaligned(a, sz);
`endif
    endfunction

    // Issue one request, follow it to its response, applying memory writes and recording observations.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [7:0] a, input logic [31:0] wd);
        int guard;
        req_write = w; req_size = sz; req_signed = sg; req_addr = {24'b0, a}; req_wdata = wd;
        req_valid = 1'b1;
        o_rdata = '0; o_err = 1'b0; o_timeout = 1'b0; o_lat = 0; o_nrd = 0; o_nwr = 0; o_bad = 0;
        o_rd_addr = '0; o_wr_data = '0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!req_ready) begin o_timeout = 1'b1; req_valid = 1'b0; return; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        o_lat = 1;
        while (o_lat < 20) begin
            @(negedge clk);
            if (mem_read) begin o_nrd++; o_rd_addr = mem_addr; end
            if (mem_write) begin o_nwr++; o_wr_data = mem_wdata; ram[mem_addr[7:2]] = mem_wdata; end
            if (mem_read && mem_write) o_bad++;
            if (!mem_read && !mem_write && (mem_addr != 0 || mem_wdata != 0)) o_bad++;
            if (resp_valid) begin o_rdata = resp_rdata; o_err = resp_err; break; end
            if (resp_rdata != 0 || resp_err != 0 || req_ready) o_bad++;
            @(posedge clk);
            o_lat++;
        end
        if (!resp_valid) o_timeout = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if ({resp_valid, resp_err} !== 2'b00 || resp_rdata !== 32'h0) begin errors++;
            $display("FAIL reset_resp: got v=%b e=%b d=%h want all 0", resp_valid, resp_err, resp_rdata); end
        checks++; if ({mem_read, mem_write} !== 2'b00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++;
            $display("FAIL reset_mem: got r=%b w=%b a=%h d=%h want all 0", mem_read, mem_write, mem_addr, mem_wdata); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word_load;
        set_word(8'h0C, 32'h0000_0008);
        do_op(1'b0, 2'd2, 1'b0, 8'h0C, 32'h0);
        checks++; if (o_timeout) begin errors++; $display("FAIL word_load_timeout: got timeout want response"); end
        checks++; if (o_rdata !== ref_load(8'h0C, 2'd2, 1'b0)) begin errors++;
            $display("FAIL word_load_data: got %h want %h", o_rdata, ref_load(8'h0C, 2'd2, 1'b0)); end
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL word_load_latency: got %0d want 3", o_lat); end
        checks++; if (o_nrd !== 1 || o_nwr !== 0) begin errors++; $display("FAIL word_load_strobes: got rd=%0d wr=%0d want 1/0", o_nrd, o_nwr); end
        checks++; if (o_rd_addr !== 32'h0C) begin errors++; $display("FAIL word_load_addr: got %h want 0000000c", o_rd_addr); end
        checks++; if (o_bad !== 0) begin errors++; $display("FAIL word_load_protocol: got %0d violations want 0", o_bad); end
    endtask

    task automatic test_byte_load;
        set_word(8'h10, 32'h12F4_5678);
        do_op(1'b0, 2'd0, 1'b1, 8'h11, 32'h0);
        checks++; if (o_rdata !== 32'hFFFF_FFF4) begin errors++; $display("FAIL byte_load_signed: got %h want fffffff4", o_rdata); end
        do_op(1'b0, 2'd0, 1'b0, 8'h11, 32'h0);
        checks++; if (o_rdata !== 32'h0000_00F4) begin errors++; $display("FAIL byte_load_unsigned: got %h want 000000f4", o_rdata); end
        do_op(1'b0, 2'd1, 1'b1, 8'h12, 32'h0);
        checks++; if (o_rdata !== ref_load(8'h12, 2'd1, 1'b1)) begin errors++;
            $display("FAIL half_load_signed: got %h want %h", o_rdata, ref_load(8'h12, 2'd1, 1'b1)); end
    endtask

    task automatic test_half_store;
        set_word(8'h20, 32'h1122_3344);
        do_op(1'b1, 2'd1, 1'b0, 8'h22, 32'h0000_BEEF);
        ref_store(8'h22, 2'd1, 32'h0000_BEEF);
        checks++; if (o_wr_data !== 32'h1122_BEEF) begin errors++; $display("FAIL half_store_wdata: got %h want 1122beef", o_wr_data); end
        checks++; if (o_lat !== 4) begin errors++; $display("FAIL half_store_latency: got %0d want 4", o_lat); end
        checks++; if (o_nrd !== 1 || o_nwr !== 1) begin errors++; $display("FAIL half_store_strobes: got rd=%0d wr=%0d want 1/1", o_nrd, o_nwr); end
        checks++; if (ram[8] !== ref_word(8'h20) || o_rdata !== 32'h0 || o_bad !== 0) begin errors++;
            $display("FAIL half_store_result: got mem=%h rdata=%h bad=%0d want %h/0/0", ram[8], o_rdata, o_bad, ref_word(8'h20)); end
    endtask

    task automatic test_misalign;
        set_word(8'h04, 32'hDEAD_BEEF);
        do_op(1'b0, 2'd2, 1'b0, 8'h06, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin errors++; $display("FAIL misalign_trap: got err=%b data=%h want 1/0", o_err, o_rdata); end
        checks++; if (o_nrd !== 0 || o_nwr !== 0 || o_lat !== 2) begin errors++;
            $display("FAIL misalign_trap_path: got rd=%0d wr=%0d lat=%0d want 0/0/2", o_nrd, o_nwr, o_lat); end
`else
        checks++; if (o_err !== 1'b0 || o_rdata !== ref_load(8'h06, 2'd2, 1'b0)) begin errors++;
            $display("FAIL misalign_ignore: got err=%b data=%h want 0/%h", o_err, o_rdata, ref_load(8'h06, 2'd2, 1'b0)); end
        checks++; if (o_rd_addr !== 32'h04 || o_lat !== 3) begin errors++;
            $display("FAIL misalign_ignore_path: got addr=%h lat=%0d want 00000004/3", o_rd_addr, o_lat); end
`endif
    endtask

    task automatic test_reset_mid_rmw;
        int guard;
        int nwr;
        set_word(8'h30, 32'hA5A5_5A5A);
        req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h31; req_wdata = 32'h77;
        req_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_rmw_in_read: got mem_read=%b want 1", mem_read); end
        rst = 1'b1;
        #1;
        checks++; if ({mem_read, mem_write} !== 2'b00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++;
            $display("FAIL rst_rmw_mem: got r=%b w=%b a=%h d=%h want all 0", mem_read, mem_write, mem_addr, mem_wdata); end
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b0) begin errors++;
            $display("FAIL rst_rmw_resp: got v=%b d=%h e=%b rdy=%b want 0/0/0/0", resp_valid, resp_rdata, resp_err, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rmw_ready: got %b want 1", req_ready); end
        nwr = 0;
        repeat (6) begin @(negedge clk); if (mem_write) nwr++; end
        checks++; if (nwr !== 0 || ram[12] !== 32'hA5A5_5A5A) begin errors++;
            $display("FAIL rst_rmw_no_write: got writes=%0d mem=%h want 0/a5a55a5a", nwr, ram[12]); end
    endtask

    task automatic test_back_to_back;
        int guard, lat1, lat2, early, overlap, nwr;
        logic [31:0] rd1;
        logic        seen1, seen2, rdy_at_resp;
        set_word(8'h40, 32'hCAFE_F00D);
        set_word(8'h44, 32'h0101_0101);
        early = 0; overlap = 0; nwr = 0; rd1 = '0; seen1 = 1'b0; seen2 = 1'b0; rdy_at_resp = 1'b0;
        req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        lat1 = 1;
        while (lat1 < 20) begin
            @(negedge clk);
            if (mem_read && mem_write) overlap++;
            if (resp_valid) begin seen1 = 1'b1; rd1 = resp_rdata; rdy_at_resp = req_ready; break; end
            if (req_ready) early++;
            @(posedge clk);
            lat1++;
        end
        req_write = 1'b1; req_addr = 32'h44; req_wdata = 32'h0BAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat2 = 1;
        while (lat2 < 20) begin
            @(negedge clk);
            if (mem_read && mem_write) overlap++;
            if (mem_write) begin nwr++; ram[mem_addr[7:2]] = mem_wdata; end
            if (resp_valid) begin seen2 = 1'b1; break; end
            if (req_ready) early++;
            @(posedge clk);
            lat2++;
        end
        ref_store(8'h44, 2'd2, 32'h0BAD_BEEF);
        checks++; if (!seen1 || !seen2) begin errors++; $display("FAIL b2b_timeout: got resp1=%b resp2=%b want 1/1", seen1, seen2); end
        checks++; if (rd1 !== ref_load(8'h40, 2'd2, 1'b0) || lat1 !== 3) begin errors++;
            $display("FAIL b2b_first: got data=%h lat=%0d want %h/3", rd1, lat1, ref_load(8'h40, 2'd2, 1'b0)); end
        checks++; if (rdy_at_resp !== 1'b1 || early !== 0) begin errors++;
            $display("FAIL b2b_handshake: got ready_at_resp=%b early=%0d want 1/0", rdy_at_resp, early); end
        checks++; if (lat2 !== 3 || nwr !== 1 || overlap !== 0) begin errors++;
            $display("FAIL b2b_second: got lat=%0d writes=%0d overlap=%0d want 3/1/0", lat2, nwr, overlap); end
        checks++; if (ram[17] !== ref_word(8'h44)) begin errors++; $display("FAIL b2b_mem: got %h want %h", ram[17], ref_word(8'h44)); end
    endtask

    task automatic test_random;
        logic        w, sg, trap;
        logic [1:0]  sz;
        logic [7:0]  a;
        logic [31:0] wd, exp_rd;
        int          exp_lat, exp_nrd, exp_nwr;
        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            wd = $urandom;
            trap    = exp_trap(a, sz);
            exp_rd  = (w || trap) ? 32'h0 : ref_load(a, sz, sg);
            exp_lat = trap ? 2 : ((!w || sz[1]) ? 3 : 4);
            exp_nrd = trap ? 0 : ((!w || !sz[1]) ? 1 : 0);
            exp_nwr = (trap || !w) ? 0 : 1;
            do_op(w, sz, sg, a, wd);
            if (w && !trap) ref_store(a, sz, wd);
            checks++; if (o_timeout) begin errors++; $display("FAIL rand_timeout op%0d: got timeout want response", n); end
            checks++; if (o_rdata !== exp_rd || o_err !== trap) begin errors++;
                $display("FAIL rand_resp op%0d: got data=%h err=%b want %h/%b", n, o_rdata, o_err, exp_rd, trap); end
            checks++; if (o_lat !== exp_lat) begin errors++; $display("FAIL rand_latency op%0d: got %0d want %0d", n, o_lat, exp_lat); end
            checks++; if (o_nrd !== exp_nrd || o_nwr !== exp_nwr || o_bad !== 0) begin errors++;
                $display("FAIL rand_strobes op%0d: got rd=%0d wr=%0d bad=%0d want %0d/%0d/0", n, o_nrd, o_nwr, o_bad, exp_nrd, exp_nwr); end
            checks++; if (ram[a[7:2]] !== ref_word(a)) begin errors++;
                $display("FAIL rand_mem op%0d: got %h want %h", n, ram[a[7:2]], ref_word(a)); end
            if (exp_nrd != 0) begin
                checks++; if (o_rd_addr !== {24'b0, a[7:2], 2'b00}) begin errors++;
                    $display("FAIL rand_addr op%0d: got %h want %h", n, o_rd_addr, {24'b0, a[7:2], 2'b00}); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) set_word(8'(i * 4), $urandom);
        test_reset;
        test_word_load;
        test_byte_load;
        test_half_store;
        test_misalign;
        test_reset_mid_rmw;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
